usb_bulk_in_fifo: RTL and testbench

- Packet FIFO directly upstream of the USB transaction layer's bulk-IN data port (bid_has_data / bid_tvalid / bid_tready / bid_tlast / bid_tdata).
- Accepts an arbitrary user AXI4-Stream and segments it into USB packets of at most MAX_PACKET bytes.
- Advertises "has complete packet" only for fully committed packets.
- Holds each sent packet until the host ACKs it, so a NAKed or timed-out IN packet is replayed byte-identically.

---
 rtl/usb_bulk_in_fifo_pkg.sv | 14 +
 rtl/usb_bulk_in_fifo_ram.sv | 23 ++
 rtl/usb_bulk_in_fifo.sv | 141 ++++++++++++++
 tb/tb_usb_bulk_in_fifo.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_bulk_in_fifo_pkg.sv
// Shared definitions for the USB bulk-IN packet FIFO: read FSM encoding and
// standard maximum packet sizes.
package usb_bulk_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } rd_state_t;

  localparam int unsigned HS_MAX_PACKET = 512;
  localparam int unsigned FS_MAX_PACKET = 64;

endpackage

// File: rtl/usb_bulk_in_fifo_ram.sv
// Simple dual-port storage for the bulk-IN FIFO: one write port and a
// registered read port whose output holds while rd_en is low.
module bulk_fifo_ram #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 9
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/usb_bulk_in_fifo.sv
// Bulk-IN packet FIFO: segments a user byte stream into USB packets, advertises
// only committed packets and keeps each sent packet until the host ACKs it.
module usb_bulk_in_fifo
  import usb_bulk_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 11,
  parameter int unsigned MAX_PACKET = HS_MAX_PACKET
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [7:0]            s_tdata,
  output logic                  has_data_o,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [7:0]            m_tdata,
  input  logic                  ack_i,
  input  logic                  rewind_i,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int unsigned PW = DEPTH_LOG2 + 1;
  localparam int unsigned BW = $clog2(MAX_PACKET);
  localparam logic [PW-1:0] CAPACITY = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [BW-1:0] LAST_IDX = BW'(MAX_PACKET - 1);

  logic [PW-1:0] wr_ptr, rd_ptr, rd_base, pkt_count, level;
  logic [BW-1:0] pkt_bytes;
  rd_state_t     state;
  logic          pf_valid, fetch_done;
  logic [8:0]    ram_q;
  logic          wr_en, close, commit, ack_take, out_free, rd_en;

  assign level    = wr_ptr - rd_base;
  assign level_o  = level;
  assign s_tready = !reset && (level != CAPACITY);
  assign wr_en    = s_tvalid && s_tready;
  assign close    = s_tlast || (pkt_bytes == LAST_IDX);
  assign commit   = wr_en && close;
  assign ack_take = (state == WAIT_ACK) && ack_i;
  assign out_free = !m_tvalid || m_tready;

  // Prefetch stops once the packet's last byte sits in the RAM output
  // register, so nothing past the packet end is ever fetched or presented.
  always_comb begin
    rd_en = 1'b0;
    case (state)
      IDLE:    rd_en = (pkt_count != '0);
      SEND:    rd_en = !rewind_i && !fetch_done && !(pf_valid && ram_q[8]) &&
                       (!pf_valid || out_free);
      default: rd_en = 1'b0;
    endcase
  end

  bulk_fifo_ram #(
    .ADDR_W(DEPTH_LOG2),
    .DATA_W(9)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
    .wr_data ({close, s_tdata}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
    .rd_data (ram_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_base    <= '0;
      pkt_count  <= '0;
      pkt_bytes  <= '0;
      has_data_o <= 1'b0;
      state      <= IDLE;
      pf_valid   <= 1'b0;
      fetch_done <= 1'b0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      m_tdata    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr    <= wr_ptr + 1'b1;
        pkt_bytes <= close ? '0 : pkt_bytes + 1'b1;
      end

      if (commit && !ack_take)      pkt_count <= pkt_count + 1'b1;
      else if (ack_take && !commit) pkt_count <= pkt_count - 1'b1;
      has_data_o <= (pkt_count != '0);

      if (rd_en) rd_ptr <= rd_ptr + 1'b1;

      case (state)
        IDLE: begin
          if (rd_en) begin
            pf_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (rewind_i) begin
            rd_ptr     <= rd_base;
            pf_valid   <= 1'b0;
            fetch_done <= 1'b0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            state      <= IDLE;
          end else begin
            if (rd_en)         pf_valid <= 1'b1;
            else if (out_free) pf_valid <= 1'b0;
            if (pf_valid && ram_q[8]) fetch_done <= 1'b1;
            if (out_free) begin
              m_tvalid <= pf_valid;
              m_tlast  <= pf_valid && ram_q[8];
              if (pf_valid) m_tdata <= ram_q[7:0];
            end
            if (m_tvalid && m_tready && m_tlast) begin
              fetch_done <= 1'b0;
              state      <= WAIT_ACK;
            end
          end
        end
        WAIT_ACK: begin
          if (ack_i) begin
            rd_base <= rd_ptr;
            state   <= IDLE;
          end else if (rewind_i) begin
            rd_ptr <= rd_base;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_bulk_in_fifo.sv
// Scoreboard bench for usb_bulk_in_fifo: expected {last,data} entries are
// queued on acceptance and held until ACK so replays compare against them.
module tb_usb_bulk_in_fifo;

  localparam int unsigned DL   = 11;
  localparam int unsigned MAXP = 512;

  logic        clock    = 1'b0;
  logic        reset    = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast  = 1'b0;
  logic [7:0]  s_tdata  = 8'h00;
  logic        has_data_o;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [7:0]  m_tdata;
  logic        ack_i    = 1'b0;
  logic        rewind_i = 1'b0;
  logic [DL:0] level_o;

  always #5 clock = ~clock;

  usb_bulk_in_fifo #(
    .DEPTH_LOG2(DL),
    .MAX_PACKET(MAXP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .s_tdata    (s_tdata),
    .has_data_o (has_data_o),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tdata    (m_tdata),
    .ack_i      (ack_i),
    .rewind_i   (rewind_i),
    .level_o    (level_o)
  );

  logic [8:0] sb[$];
  int checks   = 0;
  int failures = 0;
  int tb_pb    = 0;

  // Segmentation model: a byte closes its packet on tlast or at MAXP bytes.
  function automatic void model_accept(input logic [7:0] d, input bit last);
    bit closes;
    closes = last || (tb_pb == int'(MAXP) - 1);
    sb.push_back({closes, d});
    tb_pb = closes ? 0 : tb_pb + 1;
  endfunction

  function automatic void pop_packet();
    logic [8:0] e;
    bit done = 1'b0;
    while (!done && sb.size() != 0) begin
      e = sb.pop_front();
      done = e[8];
    end
  endfunction

  // Called and returns at posedge+1; returns right after the accepting edge.
  task automatic push_byte(input logic [7:0] d, input bit last);
    int  budget = 0;
    bit  taken  = 1'b0;
    bit  gaveup = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    while (!taken && !gaveup) begin
      @(negedge clock);
      if (s_tready) taken = 1'b1;
      @(posedge clock); #1;
      budget++;
      if (!taken && budget > 10000) begin
        gaveup = 1'b1;
        failures++;
        $display("FAIL push_timeout: s_tready stayed %0b, required 1", s_tready);
      end
    end
    if (taken) model_accept(d, last);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Receives one packet (or stop_after bytes) comparing against the queue head
  // without popping; entries are only removed on ACK.
  task automatic recv_packet(input int stop_after, input bit stalls, output int n);
    int idx    = 0;
    int budget = 0;
    bit done   = 1'b0;
    m_tready = 1'b1;
    while (!done) begin
      @(negedge clock);
      if (m_tvalid && m_tready) begin
        checks++;
        if (idx >= sb.size()) begin
          failures++;
          $display("FAIL recv_extra_byte: got %h with no expected byte left", {m_tlast, m_tdata});
          done = 1'b1;
        end else if ({m_tlast, m_tdata} !== sb[idx]) begin
          failures++;
          $display("FAIL recv_byte[%0d]: got last,data=%h required %h", idx, {m_tlast, m_tdata}, sb[idx]);
        end
        idx++;
        if (m_tlast || (stop_after != 0 && idx == stop_after)) done = 1'b1;
      end
      budget++;
      if (!done && budget > 5000) begin
        checks++;
        failures++;
        $display("FAIL recv_timeout: got %0d bytes, required a complete packet", idx);
        done = 1'b1;
      end
      @(posedge clock); #1;
      if (!done) m_tready = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    m_tready = 1'b0;
    n = idx;
  endtask

  task automatic send_ack();
    ack_i = 1'b1;
    @(posedge clock); #1;
    ack_i = 1'b0;
    pop_packet();
  endtask

  task automatic send_rewind();
    rewind_i = 1'b1;
    @(posedge clock); #1;
    rewind_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    checks++;
    if (s_tready !== 1'b0) begin
      failures++;
      $display("FAIL reset_tready_in_reset: got %0b required 0", s_tready);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({m_tvalid, has_data_o, m_tlast, m_tdata, level_o, s_tready} !== {11'b0, 12'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_values: got tvalid=%0b has=%0b tlast=%0b tdata=%h level=%0d tready=%0b required 0,0,0,00,0,1",
               m_tvalid, has_data_o, m_tlast, m_tdata, level_o, s_tready);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    int n;
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b1);
    @(negedge clock);
    checks++;
    if (has_data_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_has_data_edge_n: got %0b required 0", has_data_o);
    end
    @(negedge clock);
    checks++;
    if ({has_data_o, m_tvalid} !== 2'b10) begin
      failures++;
      $display("FAIL basic_edge_n1: got has,tvalid=%b required 10", {has_data_o, m_tvalid});
    end
    @(negedge clock);
    checks++;
    if (m_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL basic_tvalid_edge_n2: got %0b required 1", m_tvalid);
    end
    @(posedge clock); #1;
    recv_packet(0, 1'b0, n);
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL basic_len: got %0d required 3", n);
    end
    send_ack();
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({has_data_o, level_o} !== 13'd0) begin
      failures++;
      $display("FAIL basic_after_ack: got has=%0b level=%0d required 0,0", has_data_o, level_o);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_segmentation();
    int n;
    int lens[3];
    lens = '{512, 512, 76};
    fork
      begin
        for (int i = 0; i < 1100; i++) push_byte(8'(i), i == 1099);
      end
      begin
        for (int p = 0; p < 3; p++) begin
          recv_packet(0, 1'b1, n);
          checks++;
          if (n != lens[p]) begin
            failures++;
            $display("FAIL seg_len[%0d]: got %0d required %0d", p, n, lens[p]);
          end
          send_ack();
        end
      end
    join
  endtask

  task automatic test_rewind();
    int n;
    for (int i = 0; i < 64; i++) push_byte(8'(i * 3 + 7), i == 63);
    recv_packet(0, 1'b0, n);
    checks++;
    if (n != 64) begin
      failures++;
      $display("FAIL rewind_first_len: got %0d required 64", n);
    end
    send_rewind();
    recv_packet(0, 1'b0, n);
    checks++;
    if (n != 64) begin
      failures++;
      $display("FAIL rewind_replay_len: got %0d required 64", n);
    end
    send_rewind();
    recv_packet(10, 1'b0, n);
    send_rewind();
    recv_packet(0, 1'b0, n);
    checks++;
    if (n != 64) begin
      failures++;
      $display("FAIL rewind_mid_len: got %0d required 64", n);
    end
    send_ack();
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({has_data_o, level_o} !== 13'd0) begin
      failures++;
      $display("FAIL rewind_after_ack: got has=%0b level=%0d required 0,0", has_data_o, level_o);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_full();
    int n;
    for (int i = 0; i < 2048; i++) push_byte(8'(i * 7 + 1), i == 2047);
    @(negedge clock);
    checks++;
    if ({s_tready, level_o} !== {1'b0, 12'd2048}) begin
      failures++;
      $display("FAIL full_state: got tready=%0b level=%0d required 0,2048", s_tready, level_o);
    end
    @(posedge clock); #1;
    s_tvalid = 1'b1;
    s_tdata  = 8'hEE;
    s_tlast  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    recv_packet(0, 1'b0, n);
    @(negedge clock);
    checks++;
    if ({s_tready, level_o, n[9:0]} !== {1'b0, 12'd2048, 10'd512}) begin
      failures++;
      $display("FAIL full_before_ack: got tready=%0b level=%0d len=%0d required 0,2048,512", s_tready, level_o, n);
    end
    @(posedge clock); #1;
    send_ack();
    @(negedge clock);
    checks++;
    if ({s_tready, level_o} !== {1'b1, 12'd1536}) begin
      failures++;
      $display("FAIL full_reopen: got tready=%0b level=%0d required 1,1536", s_tready, level_o);
    end
    @(posedge clock); #1;
    for (int p = 0; p < 3; p++) begin
      recv_packet(0, 1'b1, n);
      checks++;
      if (n != 512) begin
        failures++;
        $display("FAIL full_drain_len[%0d]: got %0d required 512", p, n);
      end
      send_ack();
    end
    @(negedge clock);
    checks++;
    if (level_o !== 12'd0) begin
      failures++;
      $display("FAIL full_drained_level: got %0d required 0", level_o);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_commit_ack();
    int n;
    for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i), i == 3);
    recv_packet(0, 1'b0, n);
    push_byte(8'hB0, 1'b0);
    push_byte(8'hB1, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 8'hB2;
    s_tlast  = 1'b1;
    ack_i    = 1'b1;
    @(negedge clock);
    checks++;
    if (s_tready !== 1'b1) begin
      failures++;
      $display("FAIL commit_ack_tready: got %0b required 1", s_tready);
    end
    @(posedge clock); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    ack_i    = 1'b0;
    pop_packet();
    model_accept(8'hB2, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++;
      if (has_data_o !== 1'b1) begin
        failures++;
        $display("FAIL commit_ack_has_data[%0d]: got %0b required 1", c, has_data_o);
      end
    end
    @(posedge clock); #1;
    recv_packet(0, 1'b0, n);
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL commit_ack_second_len: got %0d required 3", n);
    end
    send_ack();
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (has_data_o !== 1'b0) begin
      failures++;
      $display("FAIL commit_ack_final_has: got %0b required 0", has_data_o);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < 40; i++) push_byte(8'(i + 'h40), i == 19 || i == 39);
    recv_packet(5, 1'b0, n);
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if ({m_tvalid, has_data_o, level_o, s_tready} !== 15'd0) begin
      failures++;
      $display("FAIL reset_mid: got tvalid=%0b has=%0b level=%0d tready=%0b required 0,0,0,0",
               m_tvalid, has_data_o, level_o, s_tready);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    sb.delete();
    tb_pb = 0;
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i), i == 4);
    recv_packet(0, 1'b0, n);
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL reset_mid_new_len: got %0d required 5", n);
    end
    send_ack();
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({has_data_o, level_o} !== 13'd0) begin
      failures++;
      $display("FAIL reset_mid_after_ack: got has=%0b level=%0d required 0,0", has_data_o, level_o);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_segmentation();
    test_rewind();
    test_full();
    test_commit_ack();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
